// File: rtl/lcd_rgb_rx.sv
// rtl/lcd_rgb_rx.sv - parallel RGB565 LCD receiver with coordinate recovery, timing measurement and lock
module lcd_rgb_rx #(
  parameter int EXP_WIDTH   = 800,
  parameter int EXP_HEIGHT  = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LCD_DE,
  input  logic          LCD_HSYNC,
  input  logic          LCD_VSYNC,
  input  logic [4:0]    LCD_R,
  input  logic [5:0]    LCD_G,
  input  logic [4:0]    LCD_B,
  output logic          PIX_VALID,
  output logic [10:0]   PIX_X,
  output logic [10:0]   PIX_Y,
  output logic [15:0]   PIX_DATA,
  output logic          LINE_END,
  output logic          FRAME_START,
  output logic [CW-1:0] ACT_W,
  output logic [CW-1:0] ACT_H,
  output logic [CW-1:0] H_TOTAL,
  output logic [CW-1:0] V_TOTAL,
  output logic          LOCKED,
  output logic          ERR
);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK} state_t;

  localparam logic [10:0]   XMAX = 11'h7ff;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic          de_q, hs_q, vs_q, de_p, hs_p, vs_p;
  logic [15:0]   rgb_q;
  logic          de_rise, de_fall, hs_fall, vs_fall;
  logic [10:0]   x_cnt, y_cnt, x_cur, y_cur;
  logic [CW-1:0] h_cnt, v_cnt, run_cnt, runs_final;
  logic          bad, run_bad, frame_good, pv_n;
  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          err_n;

  // Stage 0: bus capture plus one older copy for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      de_q  <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0;
      de_p  <= 1'b0; hs_p <= 1'b0; vs_p <= 1'b0;
      rgb_q <= '0;
    end else begin
      de_q  <= LCD_DE; hs_q <= LCD_HSYNC; vs_q <= LCD_VSYNC;
      de_p  <= de_q;   hs_p <= hs_q;      vs_p <= vs_q;
      rgb_q <= {LCD_R, LCD_G, LCD_B};
    end
  end

  assign de_rise = de_q & ~de_p;
  assign de_fall = ~de_q & de_p;
  assign hs_fall = hs_p & ~hs_q;
  assign vs_fall = vs_p & ~vs_q;

  assign x_cur      = de_rise ? '0 : x_cnt;
  assign y_cur      = vs_fall ? '0 : y_cnt;
  assign run_bad    = de_fall && (x_cnt != 11'(EXP_WIDTH));
  // A run ending on the VSYNC cycle still belongs to the frame being judged
  assign runs_final = (de_fall && run_cnt != CMAX) ? run_cnt + CW'(1) : run_cnt;
  assign frame_good = !(bad || run_bad) && (runs_final == CW'(EXP_HEIGHT));
  assign pv_n       = de_q && (state != S_HUNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_cnt <= '0; y_cnt <= '0; h_cnt <= '0; v_cnt <= '0; run_cnt <= '0; bad <= 1'b0;
    end else begin
      if (de_q) x_cnt <= (x_cur == XMAX) ? XMAX : x_cur + 11'd1;
      if (vs_fall) y_cnt <= '0;
      else if (de_fall && y_cnt != XMAX) y_cnt <= y_cnt + 11'd1;
      if (hs_fall) h_cnt <= CW'(1);
      else if (h_cnt != CMAX) h_cnt <= h_cnt + CW'(1);
      if (vs_fall) v_cnt <= hs_fall ? CW'(1) : '0;
      else if (hs_fall && v_cnt != CMAX) v_cnt <= v_cnt + CW'(1);
      if (vs_fall) begin
        run_cnt <= '0;
        bad     <= 1'b0;
      end else begin
        run_cnt <= runs_final;
        if (run_bad) bad <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_HUNT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = 1'b0;
    if (vs_fall) begin
      case (state)
        S_HUNT: begin
          state_n = S_VERIFY;
          cnt_n   = '0;
        end
        S_VERIFY: begin
          if (frame_good) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == 4'(LOCK_FRAMES)) state_n = S_LOCK;
          end else begin
            cnt_n = '0;
          end
        end
        S_LOCK: begin
          if (!frame_good) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = S_VERIFY;
          end
        end
        default: state_n = S_HUNT;
      endcase
    end
  end

  // Stage 1: LINE_END looks one bus sample ahead, i.e. the value entering de_q now
  always_ff @(posedge CLK) begin
    if (RST) begin
      PIX_VALID <= 1'b0; PIX_X <= '0; PIX_Y <= '0; PIX_DATA <= '0;
      LINE_END  <= 1'b0; FRAME_START <= 1'b0; ERR <= 1'b0; LOCKED <= 1'b0;
      ACT_W <= '0; ACT_H <= '0; H_TOTAL <= '0; V_TOTAL <= '0;
    end else begin
      PIX_VALID   <= pv_n;
      LINE_END    <= pv_n && !LCD_DE;
      FRAME_START <= vs_fall;
      ERR         <= err_n;
      LOCKED      <= (state_n == S_LOCK);
      if (pv_n) begin
        PIX_X    <= x_cur;
        PIX_Y    <= y_cur;
        PIX_DATA <= rgb_q;
      end
      if (hs_fall) H_TOTAL <= h_cnt;
      if (de_fall) ACT_W <= CW'(x_cnt);
      if (vs_fall) begin
        V_TOTAL <= v_cnt;
        ACT_H   <= runs_final;
      end
    end
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb/tb_lcd_rgb_rx.sv - scoreboard bench for lcd_rgb_rx on a reduced panel geometry
module tb_lcd_rgb_rx;
  localparam int EW = 8, EH = 6, LF = 2, CW = 16;
  localparam int HT = 14, VT = 10, DE0 = 3;

  logic CLK = 1'b0, RST = 1'b1;
  logic LCD_DE = 1'b0, LCD_HSYNC = 1'b1, LCD_VSYNC = 1'b1;
  logic [4:0] LCD_R = '0, LCD_B = '0;
  logic [5:0] LCD_G = '0;
  logic PIX_VALID, LINE_END, FRAME_START, LOCKED, ERR;
  logic [10:0] PIX_X, PIX_Y;
  logic [15:0] PIX_DATA;
  logic [CW-1:0] ACT_W, ACT_H, H_TOTAL, V_TOTAL;

  lcd_rgb_rx #(.EXP_WIDTH(EW), .EXP_HEIGHT(EH), .LOCK_FRAMES(LF), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .PIX_VALID(PIX_VALID), .PIX_X(PIX_X),
    .PIX_Y(PIX_Y), .PIX_DATA(PIX_DATA), .LINE_END(LINE_END), .FRAME_START(FRAME_START),
    .ACT_W(ACT_W), .ACT_H(ACT_H), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .LOCKED(LOCKED), .ERR(ERR));

  always #5 CLK = ~CLK;

  typedef struct { int x; int y; logic [15:0] data; bit last; int w; int cyc; } pix_t;
  typedef struct { bit err; bit locked; bit meas; int act_h; int act_w; } frm_t;
  pix_t pq[$];
  frm_t fq[$];
  pix_t mp;
  frm_t mf;

  int checks = 0, errors = 0, cyc = 0;
  logic rst_q = 1'b0;
  bit w_pend = 0;
  int w_exp = 0;

  bit m_hunt = 1, m_saw_vs = 0, f_all_ok = 1;
  int m_streak = 0, f_runs = 0, f_last_w = 0;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_q <= RST;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (rst_q) begin
      w_pend = 0;
      chk("reset_pix", {PIX_VALID, PIX_X, PIX_Y, PIX_DATA, LINE_END, FRAME_START, LOCKED, ERR}, 0);
      chk("reset_meas", {ACT_W, ACT_H, H_TOTAL, V_TOTAL}, 0);
    end else begin
      if (w_pend) begin
        chk("act_w_line", ACT_W, w_exp);
        w_pend = 0;
      end
      if (PIX_VALID) begin
        if (pq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          mp = pq.pop_front();
          chk("pix_xy", {PIX_X, PIX_Y}, {11'(mp.x), 11'(mp.y)});
          chk("pix_data", PIX_DATA, mp.data);
          chk("line_end", LINE_END, mp.last);
          chk("pix_latency", cyc - mp.cyc, 2);
          if (mp.last) begin
            w_pend = 1;
            w_exp  = mp.w;
          end
        end
      end else if (LINE_END) chk("line_end_stray", LINE_END, 0);
      if (FRAME_START) begin
        if (fq.size() == 0) chk("frame_unexpected", 1, 0);
        else begin
          mf = fq.pop_front();
          chk("err", ERR, mf.err);
          chk("locked", LOCKED, mf.locked);
          if (mf.meas) begin
            chk("act_h", ACT_H, mf.act_h);
            chk("v_total", V_TOTAL, VT);
            chk("act_w", ACT_W, mf.act_w);
            chk("h_total", H_TOTAL, HT);
          end
        end
      end
      chk("err_outside_frame_start", ERR && !FRAME_START, 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frame model: lock = LF consecutive good judged frames since leaving hunt
  task automatic vsync_model();
    frm_t fe;
    bit good, was;
    fe.meas  = m_saw_vs;
    fe.act_h = f_runs;
    fe.act_w = f_last_w;
    if (m_hunt) begin
      m_hunt = 0; m_streak = 0; fe.err = 0; fe.locked = 0;
    end else begin
      good      = f_all_ok && (f_runs == EH);
      was       = (m_streak >= LF);
      m_streak  = good ? m_streak + 1 : 0;
      fe.err    = was && !good;
      fe.locked = (m_streak >= LF);
    end
    fq.push_back(fe);
    m_saw_vs = 1; f_runs = 0; f_all_ok = 1;
  endtask

  task automatic frame(input int n_de, input int bad_line, input int delta,
                       input int rst_line, input bit no_vs, input bit ramp);
    pix_t p;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        int w, x, y;
        bit de;
        tick();
        RST       = (l == rst_line && c == 0);
        LCD_HSYNC = (c != 0);
        LCD_VSYNC = no_vs || (l >= 2);
        x  = c - DE0;
        y  = l - 2;
        w  = EW + ((y == bad_line) ? delta : 0);
        de = (l >= 2) && (l < 2 + n_de) && (c >= DE0) && (x < w);
        LCD_DE = de;
        if (ramp) begin
          LCD_R = x[4:0]; LCD_G = y[5:0]; LCD_B = 5'h15;
        end else {LCD_R, LCD_G, LCD_B} = 16'($urandom);
        if (RST) begin
          m_hunt = 1; m_streak = 0; m_saw_vs = 0;
        end else begin
          if (!no_vs && l == 0 && c == 0) vsync_model();
          if (de && x == 0) begin
            f_runs++;
            f_last_w = w;
            if (w != EW) f_all_ok = 0;
          end
          if (de && !m_hunt) begin
            p.x = x; p.y = y; p.data = {LCD_R, LCD_G, LCD_B};
            p.last = (x == w - 1); p.w = w; p.cyc = cyc;
            pq.push_back(p);
          end
        end
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    frame(EH, -1, 0, -1, 1, 1);
    for (int i = 0; i < 4; i++) frame(EH, -1, 0, -1, 0, i[0] == 1'b0);
    frame(EH, int'($urandom_range(0, EH - 1)), int'($urandom_range(1, 2)), -1, 0, 0);
    frame(EH, -1, 0, -1, 0, 1);
    frame(EH - 1, -1, 0, -1, 0, 0);
    frame(EH, -1, 0, -1, 0, 1);
    frame(EH, -1, 0, -1, 0, 0);
    frame(EH, -1, 0, int'($urandom_range(3, 7)), 0, 0);
    for (int i = 0; i < 4; i++) frame(EH, -1, 0, -1, 0, i[0] == 1'b1);
    tick();
    RST = 1'b0; LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b1;
    repeat (20) tick();
    chk("pixels_left", pq.size(), 0);
    chk("frames_left", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_rgb_rx.md
# lcd_rgb_rx

Parallel RGB565 LCD video receiver. It samples a DE/HSYNC/VSYNC/RGB bus in the pixel-clock domain and recovers per-pixel X/Y coordinates and line/frame markers. It measures the incoming timing and declares lock when frames match the expected geometry. It sits at the sink end of the panel timing bus, used for loopback checking of the on-board timing generator and as the capture front end for frame-buffer writers.

## Interface
- EXP_WIDTH, 800: required DE run length (pixels per active line).
- EXP_HEIGHT, 480: required DE lines per frame.
- LOCK_FRAMES, 2: consecutive good frames needed to lock (1..15).
- CW, 16: width of timing measurement counters.

Ports:
- CLK  in  1  pixel clock; all logic on rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- LCD_DE  in  1  data enable, active high.
- LCD_HSYNC  in  1  line sync, negative polarity.
- LCD_VSYNC  in  1  frame sync, negative polarity.
- LCD_R  in  5,  LCD_G  in  6,  LCD_B  in  5  pixel colour.
- PIX_VALID  out  1  pixel qualifier.
- PIX_X  out  11  column; 0 = first DE pixel of the line.
- PIX_Y  out  11  row; 0 = first DE line after VSYNC assertion.
- PIX_DATA  out  16  {R,G,B}.
- LINE_END  out  1  high with the last valid pixel of a DE run.
- FRAME_START  out  1  one-cycle pulse on VSYNC assertion.
- ACT_W, ACT_H, H_TOTAL, V_TOTAL  out  CW each  measured timing.
- LOCKED  out  1  lock status.
- ERR  out  1  one-cycle pulse on a failed frame while LOCKED.

## Operation
- Stage 0 registers all bus inputs. Sync assertion = registered sync high→low; DE edges are detected the same way.
- Stage 1 registers all outputs.
- The X counter clears on the DE rising edge and increments per DE cycle, saturating at 2047.
- The Y counter clears on VSYNC assertion and increments on each DE falling edge, saturating at 2047.
- PIX_VALID = stage-0 DE while state ≠ HUNT. PIX_X/PIX_Y/PIX_DATA are registered alongside it and hold their last value when PIX_VALID is low.
- LINE_END = stage-1 pixel valid AND stage-0 DE low. This uses the one-deep look-ahead.
- H_TOTAL: cycles between consecutive HSYNC assertions. Updated at each HSYNC assertion; internal counter saturates at 2^CW−1.
- ACT_W: DE run length, updated on each DE falling edge.
- V_TOTAL: HSYNC assertions since the previous VSYNC assertion. An HSYNC coincident with VSYNC counts toward the new frame.
- ACT_H: DE runs since the previous VSYNC assertion.
- V_TOTAL and ACT_H are latched at VSYNC assertion.
- Frame good = every DE run had length EXP_WIDTH AND the DE-run count == EXP_HEIGHT. Evaluated at VSYNC assertion; the per-frame bad flag then clears.
- FSM (state visible only through LOCKED):
  - HUNT: on VSYNC assertion → VERIFY, cnt=0. The partial frame is not judged.
  - VERIFY: on VSYNC assertion, good → cnt+1; if cnt+1 == LOCK_FRAMES → LOCKED. Bad → cnt=0, stay in VERIFY.
  - LOCKED: on VSYNC assertion, good → stay. Bad → ERR pulse, cnt=0, → VERIFY.
- LOCKED = (state == LOCKED), registered.
- DE asserted during VSYNC or without HSYNC is treated as normal pixels; there is no special case.

## Timing
- Latency: a bus sample at edge k appears on PIX_* / FRAME_START after edge k+2.
- FRAME_START, ERR and the LOCKED transition share that cycle. LOCKED reflects the frame verdict in the same cycle as ERR.
- Measurement outputs update 2 cycles after the triggering bus edge.
- Reset (including mid-frame) clears every output and counter to 0 and puts the FSM in HUNT with cnt=0. The first VSYNC assertion after reset is needed before any PIX_VALID. No ERR is issued for the interrupted frame.
- Sync inputs held low continuously produce no further assertions (edge-only).

## Test plan
- Reset → all outputs 0 for the reset cycle and after it. A bus toggling DE without VSYNC produces no PIX_VALID.
- Nominal 800x480, H total 1000, V total 525, HSYNC low 1 cycle, VSYNC low 5 lines:
  - FRAME_START at each VSYNC; LOCKED rises at the 3rd VSYNC assertion.
  - ACT_W=800, ACT_H=480, H_TOTAL=1000, V_TOTAL=525.
  - 384000 PIX_VALID per frame; LINE_END exactly at X=799 each line; last pixel X=799 Y=479.
- Colour ramp R=x[4:0], G=y[5:0], B=5'h15:
  - PIX_DATA == {x[4:0], y[5:0], 5'h15} for every valid pixel.
  - PIX_VALID is 2 cycles after the bus DE.
- While LOCKED, one line carries 801 DE pixels:
  - At the next VSYNC: ERR one cycle, LOCKED→0, ACT_W=801 after that line.
  - Relock after 2 further good frames.
- Frame with 479 DE lines while VERIFY with cnt=1 → cnt resets and no lock at that VSYNC. Lock requires 2 subsequent good frames.
- VSYNC and HSYNC asserted on the same cycle → V_TOTAL counts that line in the new frame (525 preserved).
- RST pulsed at line 200 → HUNT, outputs 0, no ERR.
